// File: rtl/bc_pkg.sv
// bc_pkg: shared state encoding and mux/ULA selector codes for the power-sum BC and datapath
package bc_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, INIT, CHECK, ADD, MUL, FIN} state_t;
    localparam logic [1:0] M0_SH   = 2'b00;
    localparam logic [1:0] M0_HX   = 2'b01;
    localparam logic [1:0] M1_X    = 2'b00;
    localparam logic [1:0] M1_ULA  = 2'b01;
    localparam logic [1:0] M2_ZERO = 2'b00;
    localparam logic [1:0] M2_ULA  = 2'b01;
    localparam logic ULA_ADD = 1'b0;
    localparam logic ULA_MUL = 1'b1;
endpackage

// File: rtl/bc_wait_cnt.sv
// bc_wait_cnt: loadable down-counter with zero flag, used to wait out the multiply latency
//   clk, RST (async active-low) ; load_i/val_i load the count ; en_i decrements ; zero_o = count is 0
module bc_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge RST)
        if (!RST) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/bc_pow_sum_ctrl.sv
// bc_pow_sum_ctrl: Moore control block sequencing X/H/S datapath to compute S = X + X^2 + ... + X^N
//   in : clk, RST (async active-low), START, N[CNT_W], ABORT (only with BC_ABORT_EN)
//   out: LX, LH, LS, SEL_ULA, M0[2], M1[2], M2[2], BUSY, DONE
//   Optional macro BC_ABORT_EN adds ABORT, which cancels a run back to IDLE without DONE.
module bc_pow_sum_ctrl import bc_pkg::*; #(
    parameter int CNT_W   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] N,
`ifdef BC_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             LX,
    output logic             LH,
    output logic             LS,
    output logic             SEL_ULA,
    output logic [1:0]       M0,
    output logic [1:0]       M1,
    output logic [1:0]       M2,
    output logic             BUSY,
    output logic             DONE
);
    localparam int WW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wz;
    logic             abort;
`ifdef BC_ABORT_EN
    assign abort = ABORT && state_q != IDLE;
`else
    assign abort = 1'b0;
`endif
    // wz marks the last MUL cycle; with single-cycle multiply every MUL cycle is the last
    if (MUL_LAT > 1) begin : g_wait
        bc_wait_cnt #(.W(WW)) u_wait (
            .clk    (clk),
            .RST    (RST),
            .load_i (state_q == ADD),
            .en_i   (state_q == MUL),
            .val_i  (WW'(MUL_LAT - 1)),
            .zero_o (wz)
        );
    end else begin : g_nowait
        assign wz = 1'b1;
    end
    always_ff @(posedge clk or negedge RST)
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (abort) state_q <= IDLE;
        else case (state_q)
            IDLE:  if (START) begin
                cnt_q   <= N;
                state_q <= LOAD;
            end
            LOAD:  state_q <= INIT;
            INIT:  state_q <= CHECK;
            CHECK: state_q <= cnt_q == '0 ? FIN : ADD;
            ADD:   state_q <= MUL;
            MUL:   if (wz) begin
                state_q <= CHECK;
                if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
            FIN:   state_q <= IDLE;
            default: state_q <= IDLE;
        endcase
    // load enables are gated by abort so a cancelled cycle never disturbs the datapath
    assign LX      = state_q == LOAD && !abort;
    assign LH      = (state_q == INIT || (state_q == MUL && wz)) && !abort;
    assign LS      = (state_q == INIT || state_q == ADD) && !abort;
    assign SEL_ULA = state_q == MUL ? ULA_MUL : ULA_ADD;
    assign M0      = state_q == MUL ? M0_HX : M0_SH;
    assign M1      = state_q == MUL && wz ? M1_ULA : M1_X;
    assign M2      = state_q == ADD ? M2_ULA : M2_ZERO;
    assign BUSY    = state_q != IDLE;
    assign DONE    = state_q == FIN && !abort;
endmodule

// File: tb/tb_bc_pow_sum_ctrl.sv
// tb_bc_pow_sum_ctrl: randomized directed bench for bc_pow_sum_ctrl (MUL_LAT=1 and MUL_LAT=3 instances)
module tb_bc_pow_sum_ctrl;
    logic clk = 0, rst_n = 0, start = 0, sel = 0, abort = 0;
    logic [3:0] nin = 0;
    logic [31:0] xin = 0;
    int checks = 0, errors = 0;
    logic lx1, lh1, ls1, su1, b1, d1, lx3, lh3, ls3, su3, b3, d3;
    logic [1:0] m01, m11, m21, m03, m13, m23;
    logic [11:0] o1, o3, o;
    always #5 clk = ~clk;
    bc_pow_sum_ctrl #(.CNT_W(4), .MUL_LAT(1)) dut1 (
        .clk(clk), .RST(rst_n), .START(start && !sel), .N(nin),
`ifdef BC_ABORT_EN
        .ABORT(abort && !sel),
`endif
        .LX(lx1), .LH(lh1), .LS(ls1), .SEL_ULA(su1), .M0(m01), .M1(m11), .M2(m21), .BUSY(b1), .DONE(d1));
    bc_pow_sum_ctrl #(.CNT_W(4), .MUL_LAT(3)) dut3 (
        .clk(clk), .RST(rst_n), .START(start && sel), .N(nin),
`ifdef BC_ABORT_EN
        .ABORT(abort && sel),
`endif
        .LX(lx3), .LH(lh3), .LS(ls3), .SEL_ULA(su3), .M0(m03), .M1(m13), .M2(m23), .BUSY(b3), .DONE(d3));
    assign o1 = {lx1, lh1, ls1, su1, m01, m11, m21, b1, d1};
    assign o3 = {lx3, lh3, ls3, su3, m03, m13, m23, b3, d3};
    assign o  = sel ? o3 : o1;
    // datapath model driven by the selected controller
    logic [31:0] xr = 0, hr = 0, sr = 0, ula;
    assign ula = o[8] ? (o[7:6] == 2'b01 ? hr * xr : sr * hr) : (o[7:6] == 2'b01 ? hr + xr : sr + hr);
    always @(posedge clk) begin
        if (o[11]) xr <= xin;
        if (o[10]) hr <= o[5:4] == 2'b01 ? ula : xr;
        if (o[9])  sr <= o[3:2] == 2'b01 ? ula : 32'd0;
    end
    // expected outputs in cycle t after the accepting edge, from the timing rules
    function automatic logic [11:0] exp_out(input int t, input int n, input int l);
        int p, dt, r;
        logic lx, lh, ls, su, bz, dn;
        logic [1:0] m0, m1, m2;
        p = 2 + l; dt = 4 + n * p;
        lx = t == 1; lh = t == 2; ls = t == 2; su = 0; m0 = 0; m1 = 0; m2 = 0;
        bz = t >= 1 && t <= dt; dn = t == dt;
        if (t >= 4 && t < dt) begin
            r = (t - 4) % p;
            if (r == 0) begin ls = 1; m2 = 2'b01; end
            else if (r <= l) begin
                su = 1; m0 = 2'b01;
                if (r == l) begin lh = 1; m1 = 2'b01; end
            end
        end
        return {lx, lh, ls, su, m0, m1, m2, bz, dn};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic go(input int n, input logic [31:0] x);
        start = 1; nin = 4'(n); xin = x;
    endtask
    // follow one run cycle by cycle with START/N scrambled while busy
    task automatic track(input int n, input bit hold, input int next_n);
        int l, dt, adds, muls;
        logic [31:0] s, pw;
        l = sel ? 3 : 1; dt = 4 + n * (2 + l); adds = 0; muls = 0;
        for (int t = 1; t <= dt + 1; t++) begin
            @(negedge clk);
            chk($sformatf("out L%0d N%0d t%0d", l, n, t), 32'(o), 32'(exp_out(t, n, l)));
            if (o[9] && o[3:2] == 2'b01) adds++;
            if (o[10] && o[5:4] == 2'b01) muls++;
            if (t <= dt) begin
                start = hold | 1'($urandom);
                nin = 4'($urandom);
            end else begin
                start = hold;
                nin = 4'(next_n);
            end
        end
        s = 0; pw = 1;
        for (int k = 0; k < n; k++) begin pw = pw * xin; s = s + pw; end
        chk($sformatf("S L%0d N%0d X%0d", l, n, xin), sr, s);
        chk("add loads", 32'(adds), 32'(n));
        chk("mul loads", 32'(muls), 32'(n));
    endtask
    initial begin
        start = 1;
        repeat (3) begin
            @(negedge clk);
            chk("reset L1", 32'(o1), 0);
            chk("reset L3", 32'(o3), 0);
        end
        rst_n = 1; start = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle L1", 32'(o1), 0);
            chk("idle L3", 32'(o3), 0);
        end
        go(0, 5); track(0, 0, 0);
        go(3, 2); track(3, 0, 0);
        chk("S=14", sr, 14);
        sel = 1;
        go(2, 3); track(2, 0, 0);
        for (int i = 0; i < 6; i++) begin
            sel = 1'(i);
            go(int'($urandom_range(5)), 32'($urandom_range(7)));
            track(int'(nin), 0, 0);
        end
        sel = 0;
        go(2, 3); track(2, 1, 1); track(1, 0, 0);
        @(negedge clk);
        chk("idle after restart", 32'(o), 0);
        sel = 1;
        go(2, 2);
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            chk($sformatf("pre-rst t%0d", t), 32'(o), 32'(exp_out(t, 2, 3)));
            start = 0;
        end
        #1 rst_n = 0;
        #1 chk("async rst in MUL", 32'(o3), 0);
        @(negedge clk);
        chk("rst held", 32'(o3), 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle after rst", 32'(o3), 0);
        go(1, 6); track(1, 0, 0);
`ifdef BC_ABORT_EN
        sel = 0;
        go(2, 3);
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            chk($sformatf("pre-abort t%0d", t), 32'(o), 32'(exp_out(t, 2, 1)));
            start = 0;
        end
        abort = 1;
        #1 chk("abort ADD", 32'(o1), 32'(exp_out(4, 2, 1) & 12'h1FF));
        @(negedge clk);
        chk("abort idle", 32'(o1), 0);
        abort = 0;
        repeat (12) begin
            @(negedge clk);
            chk("no DONE after abort", 32'(o1), 0);
        end
        go(1, 4); track(1, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
